// File: rtl/sram_user_cmd.sv
// sram_user_cmd: push-button front end for the SRAM controller.
// The keys and switches pass through two-flop synchronisers, and each key is
// debounced. Every clean press becomes exactly one command. The command is
// held on a valid/ready handshake until the controller accepts it.
module sram_user_cmd #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int ADDR_W          = 4,
   parameter int DATA_W          = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              key_write_n,
   input  logic              key_read_n,
   input  logic [ADDR_W-1:0] sw_address,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              cmd_ready,
   output logic              cmd_valid,
   output logic              cmd_write,
   output logic [ADDR_W-1:0] cmd_address,
   output logic [DATA_W-1:0] cmd_data,
   output logic              busy,
   output logic              overrun
);

   // Key vectors use index 1 for the write key and index 0 for the read key.
   localparam int KW = 1;
   localparam int KR = 0;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RELEASE} state_t;

   logic [1:0]        key_p0, key_p1;
   logic [ADDR_W-1:0] addr_p0, addr_p1;
   logic [DATA_W-1:0] data_p0, data_p1;
   logic [1:0]        deb, deb_q, press;
   logic [CNT_W-1:0]  cnt [2];
   state_t            state;

   // Two-flop synchronisers. Keys idle high (released) and switches idle at zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_p0  <= '1;
         key_p1  <= '1;
         addr_p0 <= '0;
         addr_p1 <= '0;
         data_p0 <= '0;
         data_p1 <= '0;
      end else begin
         key_p0  <= {key_write_n, key_read_n};
         key_p1  <= key_p0;
         addr_p0 <= sw_address;
         addr_p1 <= addr_p0;
         data_p0 <= sw_data;
         data_p1 <= data_p0;
      end
   end

   // Per-key debouncer. A level is accepted only after it stays stable long enough.
   // The press pulse is registered one cycle after the debounced fall, so
   // the FSM reacts to the press DEBOUNCE_CYCLES+3 edges after the raw fall.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         deb   <= '1;
         deb_q <= '1;
         press <= '0;
         for (int k = 0; k < 2; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (key_p1[k] != deb[k]) begin
               if (cnt[k] == DEB_LAST) begin
                  deb[k] <= key_p1[k];
                  cnt[k] <= '0;
               end else begin
                  cnt[k] <= cnt[k] + CNT_W'(1);
               end
            end else begin
               cnt[k] <= '0;
            end
            deb_q[k] <= deb[k];
            press[k] <= deb_q[k] & ~deb[k];
         end
      end
   end

   // Command FSM. It latches a command on a press and holds it until the
   // controller accepts it. It then waits for both keys to be released.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cmd_valid   <= 1'b0;
         cmd_write   <= 1'b0;
         cmd_address <= '0;
         cmd_data    <= '0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (press[KW] || press[KR]) begin
                  cmd_address <= addr_p1;
                  cmd_data    <= data_p1;
                  cmd_write   <= press[KW];
                  cmd_valid   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= ISSUE;
                  if (press[KW] && press[KR]) overrun <= 1'b1;
               end
            end
            ISSUE: begin
               if (|press) overrun <= 1'b1;
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (|press) overrun <= 1'b1;
               if (&deb) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               cmd_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_user_cmd.sv
// Directed testbench for sram_user_cmd with DEBOUNCE_CYCLES = 4. Expected
// values are hand-derived. With the key falling before edge 0, cmd_valid
// first reads 1 after edge 7.
module tb_sram_user_cmd;

   localparam int DEB = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key_write_n = 1'b1;
   logic       key_read_n = 1'b1;
   logic [3:0] sw_address = '0;
   logic [3:0] sw_data = '0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid, cmd_write, busy, overrun;
   logic [3:0] cmd_address, cmd_data;

   int checks = 0;
   int errors = 0;
   int vcount = 0;

   sram_user_cmd #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(4),
      .ADDR_W(4),
      .DATA_W(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .key_write_n(key_write_n),
      .key_read_n(key_read_n),
      .sw_address(sw_address),
      .sw_data(sw_data),
      .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid),
      .cmd_write(cmd_write),
      .cmd_address(cmd_address),
      .cmd_data(cmd_data),
      .busy(busy),
      .overrun(overrun)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1 ns later. Also count the cycles in which valid is high.
   task automatic tick();
      @(posedge clock);
      #1;
      if (cmd_valid) vcount++;
   endtask

   task automatic do_reset();
      key_write_n = 1'b1;
      key_read_n  = 1'b1;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      // Reset state
      tick();
      check_eq("rst_valid", {31'd0, cmd_valid}, 32'd0);
      check_eq("rst_write", {31'd0, cmd_write}, 32'd0);
      check_eq("rst_addr", {28'd0, cmd_address}, 32'd0);
      check_eq("rst_data", {28'd0, cmd_data}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_ovr", {31'd0, overrun}, 32'd0);
      do_reset();

      // Write command with ready asserted
      cmd_ready = 1'b1; sw_address = 4'hA; sw_data = 4'h5;
      key_write_n = 1'b0; vcount = 0;
      repeat (7) tick();
      check_eq("wr_early", vcount, 0);
      tick();
      check_eq("wr_valid", {31'd0, cmd_valid}, 32'd1);
      check_eq("wr_write", {31'd0, cmd_write}, 32'd1);
      check_eq("wr_addr", {28'd0, cmd_address}, 32'hA);
      check_eq("wr_data", {28'd0, cmd_data}, 32'h5);
      check_eq("wr_busy", {31'd0, busy}, 32'd1);
      tick();
      check_eq("wr_drop", {31'd0, cmd_valid}, 32'd0);
      check_eq("wr_busy_held", {31'd0, busy}, 32'd1);
      repeat (11) tick();
      key_write_n = 1'b1;
      repeat (12) tick();
      check_eq("wr_idle", {31'd0, busy}, 32'd0);
      check_eq("wr_count", vcount, 1);

      // Back-pressure on a read command
      cmd_ready = 1'b0; sw_address = 4'h3; sw_data = 4'h7;
      key_read_n = 1'b0;
      repeat (8) tick();
      check_eq("bp_valid", {31'd0, cmd_valid}, 32'd1);
      check_eq("bp_write", {31'd0, cmd_write}, 32'd0);
      repeat (20) tick();
      sw_address = 4'hF; sw_data = 4'hF;
      repeat (22) tick();
      check_eq("bp_hold_valid", {31'd0, cmd_valid}, 32'd1);
      check_eq("bp_hold_addr", {28'd0, cmd_address}, 32'h3);
      check_eq("bp_hold_data", {28'd0, cmd_data}, 32'h7);
      check_eq("bp_hold_write", {31'd0, cmd_write}, 32'd0);
      cmd_ready = 1'b1;
      tick();
      check_eq("bp_xfer", {31'd0, cmd_valid}, 32'd0);
      key_read_n = 1'b1;
      repeat (12) tick();
      check_eq("bp_idle", {31'd0, busy}, 32'd0);
      check_eq("bp_ovr", {31'd0, overrun}, 32'd0);

      // Glitch rejection: a 3-cycle low pulse on both keys
      vcount = 0;
      key_write_n = 1'b0; key_read_n = 1'b0;
      repeat (3) tick();
      key_write_n = 1'b1; key_read_n = 1'b1;
      repeat (20) tick();
      check_eq("gl_count", vcount, 0);
      check_eq("gl_ovr", {31'd0, overrun}, 32'd0);
      check_eq("gl_busy", {31'd0, busy}, 32'd0);

      // Simultaneous press: the write wins and overrun is set
      sw_address = 4'h6; sw_data = 4'h9; vcount = 0;
      key_write_n = 1'b0; key_read_n = 1'b0;
      repeat (8) tick();
      check_eq("sim_valid", {31'd0, cmd_valid}, 32'd1);
      check_eq("sim_write", {31'd0, cmd_write}, 32'd1);
      check_eq("sim_addr", {28'd0, cmd_address}, 32'h6);
      check_eq("sim_ovr", {31'd0, overrun}, 32'd1);
      repeat (12) tick();
      key_write_n = 1'b1; key_read_n = 1'b1;
      repeat (15) tick();
      check_eq("sim_count", vcount, 1);
      check_eq("sim_idle", {31'd0, busy}, 32'd0);

      // Overrun during ISSUE
      do_reset();
      check_eq("ovr_clear", {31'd0, overrun}, 32'd0);
      cmd_ready = 1'b0; sw_address = 4'h2; sw_data = 4'h1;
      key_write_n = 1'b0;
      repeat (8) tick();
      check_eq("ovr_valid", {31'd0, cmd_valid}, 32'd1);
      check_eq("ovr_pre", {31'd0, overrun}, 32'd0);
      key_read_n = 1'b0;
      repeat (10) tick();
      key_read_n = 1'b1;
      repeat (10) tick();
      check_eq("ovr_set", {31'd0, overrun}, 32'd1);
      check_eq("ovr_keep_write", {31'd0, cmd_write}, 32'd1);
      check_eq("ovr_keep_addr", {28'd0, cmd_address}, 32'h2);
      cmd_ready = 1'b1; vcount = 0;
      tick();
      check_eq("ovr_xfer", {31'd0, cmd_valid}, 32'd0);
      key_write_n = 1'b1;
      repeat (15) tick();
      check_eq("ovr_no_second", vcount, 0);
      check_eq("ovr_idle", {31'd0, busy}, 32'd0);

      // Reset mid-handshake while the key stays held
      cmd_ready = 1'b0; sw_address = 4'hC; sw_data = 4'h4;
      key_write_n = 1'b0;
      repeat (8) tick();
      check_eq("mr_valid", {31'd0, cmd_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_eq("mr_async_valid", {31'd0, cmd_valid}, 32'd0);
      check_eq("mr_async_write", {31'd0, cmd_write}, 32'd0);
      check_eq("mr_async_addr", {28'd0, cmd_address}, 32'd0);
      check_eq("mr_async_data", {28'd0, cmd_data}, 32'd0);
      check_eq("mr_async_busy", {31'd0, busy}, 32'd0);
      check_eq("mr_async_ovr", {31'd0, overrun}, 32'd0);
      #2 reset = 1'b1;
      vcount = 0;
      repeat (7) tick();
      check_eq("mr_early", vcount, 0);
      tick();
      check_eq("mr_new_valid", {31'd0, cmd_valid}, 32'd1);
      check_eq("mr_new_addr", {28'd0, cmd_address}, 32'hC);
      check_eq("mr_new_write", {31'd0, cmd_write}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
